// File: rtl/ysyx_bus_arbiter_pkg.sv
// ============================================================================
// Module      : ysyx_bus_arbiter_pkg
// Description : Shared encodings for the IFU/LSU bus arbiter (FSM, owner, strobes)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWNER_IFU = 1'b0,
        OWNER_LSU = 1'b1
    } owner_e;

    localparam logic [7:0] IFU_STRB   = 8'h0f;
    localparam logic [1:0] STARVE_MAX = 2'd3;

    // Saturating increment of the IFU starvation counter
    function automatic logic [1:0] starve_inc(input logic [1:0] cnt);
        return (cnt == STARVE_MAX) ? STARVE_MAX : cnt + 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_bus_arbiter.sv
// ============================================================================
// Module      : ysyx_bus_arbiter
// Description : Two-requester (IFU/LSU) arbiter onto one shared memory bus
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_bus_arbiter
    import ysyx_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_rvalid,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_arvalid,
    input  logic              lsu_awvalid,
    input  logic [7:0]        lsu_rstrb,
    input  logic [7:0]        lsu_wstrb,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,
    output logic              lsu_wready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [7:0]        mem_strb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);

    state_e            state_q,  state_d;
    owner_e            owner_q,  owner_d;
    logic [1:0]        starve_q, starve_d;
    logic              we_q,     we_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [7:0]        strb_q,   strb_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;

    logic w_ifu_forced;
    logic w_grant_st;
    logic w_grant_ld;
    logic w_grant_ifu;
    logic w_resp;

    // Starvation guard overrides the normal store > load > fetch order
    assign w_ifu_forced = (starve_q == STARVE_MAX) && ifu_arvalid;
    assign w_grant_st   = !w_ifu_forced && lsu_awvalid;
    assign w_grant_ld   = !w_ifu_forced && !lsu_awvalid && lsu_arvalid;
    assign w_grant_ifu  = w_ifu_forced || (!lsu_awvalid && !lsu_arvalid && ifu_arvalid);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        we_d     = we_q;
        addr_d   = addr_q;
        strb_d   = strb_q;
        wdata_d  = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (w_grant_ifu) begin
                    state_d  = ST_REQ;
                    owner_d  = OWNER_IFU;
                    starve_d = 2'd0;
                    we_d     = 1'b0;
                    addr_d   = ifu_araddr;
                    strb_d   = IFU_STRB;
                    wdata_d  = '0;
                end else if (w_grant_st || w_grant_ld) begin
                    state_d  = ST_REQ;
                    owner_d  = OWNER_LSU;
                    starve_d = ifu_arvalid ? starve_inc(starve_q) : 2'd0;
                    we_d     = w_grant_st;
                    addr_d   = lsu_addr;
                    strb_d   = w_grant_st ? lsu_wstrb : lsu_rstrb;
                    wdata_d  = w_grant_st ? lsu_wdata : '0;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWNER_IFU;
            starve_q <= 2'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            strb_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            strb_q   <= strb_d;
            wdata_q  <= wdata_d;
        end
    end

    assign mem_valid = (state_q == ST_REQ);
    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_strb  = strb_q;
    assign mem_wdata = wdata_q;

    // Response pulses follow mem_rvalid combinationally, only while awaiting it
    assign w_resp     = (state_q == ST_RESP) && mem_rvalid;
    assign ifu_rvalid = w_resp && (owner_q == OWNER_IFU);
    assign lsu_rvalid = w_resp && (owner_q == OWNER_LSU) && !we_q;
    assign lsu_wready = w_resp && (owner_q == OWNER_LSU) && we_q;
    assign ifu_rdata  = mem_rdata;
    assign lsu_rdata  = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_bus_arbiter.sv
// ============================================================================
// Module      : tb_ysyx_bus_arbiter
// Description : Self-checking bench for ysyx_bus_arbiter with a transaction model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ifu_araddr;
    logic          ifu_arvalid;
    logic [DW-1:0] ifu_rdata;
    logic          ifu_rvalid;
    logic [AW-1:0] lsu_addr;
    logic          lsu_arvalid;
    logic          lsu_awvalid;
    logic [7:0]    lsu_rstrb;
    logic [7:0]    lsu_wstrb;
    logic [DW-1:0] lsu_wdata;
    logic [DW-1:0] lsu_rdata;
    logic          lsu_rvalid;
    logic          lsu_wready;
    logic [AW-1:0] mem_addr;
    logic          mem_valid;
    logic          mem_we;
    logic [7:0]    mem_strb;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;

    int errors = 0;
    int checks = 0;
    int starve = 0;

    ysyx_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
        .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
        .lsu_addr(lsu_addr), .lsu_arvalid(lsu_arvalid), .lsu_awvalid(lsu_awvalid),
        .lsu_rstrb(lsu_rstrb), .lsu_wstrb(lsu_wstrb), .lsu_wdata(lsu_wdata),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid), .lsu_wready(lsu_wready),
        .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_we(mem_we),
        .mem_strb(mem_strb), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; lsu_awvalid = 1'b0;
        ifu_araddr = '0; lsu_addr = '0; lsu_rstrb = '0; lsu_wstrb = '0; lsu_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        step();
        step();
        rst = 1'b0;
        starve = 0;
    endtask

    // One complete bus transaction from the current IDLE cycle back to IDLE.
    // win_o: 0 = IFU fetch, 1 = LSU load, 2 = LSU store.
    task automatic serve_one(input int ready_dly, input int rvalid_dly,
                             input logic [DW-1:0] rdata, input bit noise,
                             output int win_o);
        int            win;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [7:0]    e_strb;
        logic          e_we;
        logic [2:0]    e_pulse;
        if (starve == 3 && ifu_arvalid) win = 0;
        else if (lsu_awvalid)           win = 2;
        else if (lsu_arvalid)           win = 1;
        else                            win = 0;
        case (win)
            0:       begin e_addr = ifu_araddr; e_we = 1'b0; e_strb = 8'h0f;     e_wdata = '0;        e_pulse = 3'b100; end
            1:       begin e_addr = lsu_addr;   e_we = 1'b0; e_strb = lsu_rstrb; e_wdata = '0;        e_pulse = 3'b010; end
            default: begin e_addr = lsu_addr;   e_we = 1'b1; e_strb = lsu_wstrb; e_wdata = lsu_wdata; e_pulse = 3'b001; end
        endcase
        if (win == 0)         starve = 0;
        else if (ifu_arvalid) starve = (starve == 3) ? 3 : starve + 1;
        else                  starve = 0;
        win_o = win;
        step();
        for (int k = 0; k <= ready_dly; k++) begin
            checks++;
            if (mem_valid !== 1'b1 || mem_addr !== e_addr || mem_we !== e_we ||
                mem_strb !== e_strb || mem_wdata !== e_wdata)
                $display("FAIL req_fields cyc%0d: got v=%b a=%h we=%b s=%h d=%h want v=1 a=%h we=%b s=%h d=%h",
                         k, mem_valid, mem_addr, mem_we, mem_strb, mem_wdata, e_addr, e_we, e_strb, e_wdata);
            if (mem_valid !== 1'b1 || mem_addr !== e_addr || mem_we !== e_we ||
                mem_strb !== e_strb || mem_wdata !== e_wdata) errors++;
            mem_ready  = (k == ready_dly);
            mem_rvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata  = $urandom;
            #1;
            checks++;
            if ({ifu_rvalid, lsu_rvalid, lsu_wready} !== 3'b000) begin
                errors++;
                $display("FAIL pulse_in_req: got %b want 000", {ifu_rvalid, lsu_rvalid, lsu_wready});
            end
            step();
        end
        mem_ready = 1'b0;
        for (int k = 0; k < rvalid_dly; k++) begin
            mem_rvalid = 1'b0;
            #1;
            checks++;
            if (mem_valid !== 1'b0 || {ifu_rvalid, lsu_rvalid, lsu_wready} !== 3'b000) begin
                errors++;
                $display("FAIL resp_wait: got valid=%b pulses=%b want 0/000",
                         mem_valid, {ifu_rvalid, lsu_rvalid, lsu_wready});
            end
            step();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        #1;
        checks++;
        if ({ifu_rvalid, lsu_rvalid, lsu_wready} !== e_pulse) begin
            errors++;
            $display("FAIL resp_pulse: got %b want %b", {ifu_rvalid, lsu_rvalid, lsu_wready}, e_pulse);
        end
        checks++;
        if (ifu_rdata !== rdata || lsu_rdata !== rdata) begin
            errors++;
            $display("FAIL resp_data: got ifu=%h lsu=%h want %h", ifu_rdata, lsu_rdata, rdata);
        end
        step();
        mem_rvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        case (win)
            0:       ifu_arvalid = 1'b0;
            1:       lsu_arvalid = 1'b0;
            default: lsu_awvalid = 1'b0;
        endcase
        #1;
        checks++;
        if (mem_valid !== 1'b0 || {ifu_rvalid, lsu_rvalid, lsu_wready} !== 3'b000) begin
            errors++;
            $display("FAIL back_to_idle: got valid=%b pulses=%b want 0/000",
                     mem_valid, {ifu_rvalid, lsu_rvalid, lsu_wready});
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (mem_valid !== 1'b0 || mem_we !== 1'b0 || mem_strb !== 8'h00 ||
            mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_bus: got v=%b we=%b s=%h a=%h d=%h want all 0",
                     mem_valid, mem_we, mem_strb, mem_addr, mem_wdata);
        end
        mem_rvalid = 1'b1;
        #1;
        checks++;
        if ({ifu_rvalid, lsu_rvalid, lsu_wready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle_rvalid: got %b want 000", {ifu_rvalid, lsu_rvalid, lsu_wready});
        end
        step();
        mem_rvalid = 1'b0;
        checks++;
        if (mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_stray_rvalid: mem_valid got %b want 0", mem_valid);
        end
    endtask

    task automatic test_ifu_read();
        int w;
        ifu_araddr  = 32'h8000_0000;
        ifu_arvalid = 1'b1;
        serve_one(0, 0, 32'hDEAD_BEEF, 1'b0, w);
        checks++;
        if (w != 0) begin errors++; $display("FAIL ifu_read_winner: got %0d want 0", w); end
    endtask

    task automatic test_ifu_vs_load();
        int w0, w1;
        ifu_araddr = 32'h8000_0040; ifu_arvalid = 1'b1;
        lsu_addr = 32'h8000_0100; lsu_rstrb = 8'hff; lsu_arvalid = 1'b1;
        serve_one(0, 1, $urandom, 1'b0, w0);
        serve_one(1, 0, $urandom, 1'b0, w1);
        checks++;
        if (w0 != 1 || w1 != 0) begin
            errors++;
            $display("FAIL ifu_vs_load_order: got %0d,%0d want 1,0", w0, w1);
        end
    endtask

    task automatic test_starvation();
        int got[8];
        int exp_order[8] = '{2, 2, 2, 0, 2, 2, 2, 0};
        do_reset();
        ifu_araddr = 32'h8000_1000; ifu_arvalid = 1'b1;
        lsu_addr = 32'h9000_0000; lsu_wstrb = 8'hf0; lsu_wdata = $urandom; lsu_awvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            serve_one(0, 0, $urandom, 1'b0, got[i]);
            if (!lsu_awvalid) begin lsu_wdata = $urandom; lsu_awvalid = 1'b1; end
            if (!ifu_arvalid) begin ifu_araddr = ifu_araddr + 4; ifu_arvalid = 1'b1; end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] != exp_order[i]) begin
                errors++;
                $display("FAIL starve_order[%0d]: got %0d want %0d", i, got[i], exp_order[i]);
            end
        end
        ifu_arvalid = 1'b0; lsu_awvalid = 1'b0;
        step();
        starve = 0;
    endtask

    task automatic test_store_delayed();
        int w;
        lsu_addr = 32'hA000_0004; lsu_wdata = 32'h1234_5678; lsu_wstrb = 8'h03;
        lsu_awvalid = 1'b1;
        serve_one(3, 0, $urandom, 1'b1, w);
        checks++;
        if (w != 2) begin errors++; $display("FAIL store_delayed_winner: got %0d want 2", w); end
    endtask

    task automatic test_store_load();
        int w0, w1;
        lsu_addr = 32'hB000_0010; lsu_wdata = $urandom; lsu_wstrb = 8'h0c; lsu_rstrb = 8'h01;
        lsu_arvalid = 1'b1; lsu_awvalid = 1'b1;
        serve_one(0, 0, $urandom, 1'b0, w0);
        serve_one(2, 1, $urandom, 1'b0, w1);
        checks++;
        if (w0 != 2 || w1 != 1) begin
            errors++;
            $display("FAIL store_load_order: got %0d,%0d want 2,1", w0, w1);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        do_reset();
        ifu_araddr = 32'h8000_2000; ifu_arvalid = 1'b1;
        step();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        starve = 0;
        ifu_arvalid = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        checks++;
        if ({ifu_rvalid, lsu_rvalid, lsu_wready} !== 3'b000 || mem_valid !== 1'b0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_mid: got pulses=%b valid=%b addr=%h want 000/0/0",
                     {ifu_rvalid, lsu_rvalid, lsu_wready}, mem_valid, mem_addr);
        end
        step();
        mem_rvalid = 1'b0;
        lsu_addr = 32'hC000_0000; lsu_rstrb = 8'h0f; lsu_arvalid = 1'b1;
        serve_one(0, 0, $urandom, 1'b0, w);
        checks++;
        if (w != 1) begin errors++; $display("FAIL reset_mid_next: got %0d want 1", w); end
    endtask

    task automatic refill();
        if (!ifu_arvalid && $urandom_range(0, 1) == 1) begin
            ifu_araddr = 32'h8000_0000 | ($urandom & 32'h00ff_fffc);
            ifu_arvalid = 1'b1;
        end
        if (!lsu_arvalid && !lsu_awvalid) begin
            lsu_addr = 32'h9000_0000 | ($urandom & 32'h00ff_ffff);
            lsu_rstrb = 8'($urandom);
            if ($urandom_range(0, 2) == 0) lsu_arvalid = 1'b1;
        end
        if (!lsu_awvalid && $urandom_range(0, 2) == 0) begin
            lsu_wstrb = 8'($urandom);
            lsu_wdata = $urandom;
            lsu_awvalid = 1'b1;
        end
        if (!ifu_arvalid && !lsu_arvalid && !lsu_awvalid) begin
            ifu_araddr = 32'h8000_0000 | ($urandom & 32'h00ff_fffc);
            ifu_arvalid = 1'b1;
        end
    endtask

    task automatic test_random();
        int w;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            refill();
            serve_one($urandom_range(0, 3), $urandom_range(0, 2), $urandom, 1'b1, w);
        end
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_ifu_vs_load();
        test_starvation();
        test_store_delayed();
        test_store_load();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
